// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: round-robin share of the single write port
// between two requesters, plus a pending-write scoreboard for RAW/WAW stalls.
module rf_wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_rd,
    output logic          iss_ready,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic          busy1,
    output logic          busy2,
    output logic          rf_wr,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd
);
    localparam int NREG = 1 << AW;

    // last_q = 1 means req1 won the most recent transfer, so req0 wins a tie
    logic            last_q, last_d;
    logic            rf_wr_q, rf_wr_d;
    logic [AW-1:0]   rf_wa_q, rf_wa_d;
    logic [DW-1:0]   rf_wd_q, rf_wd_d;
    logic [NREG-1:0] pending_q, pending_d;

    logic            gnt0, gnt1, xfer, iss_fire;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    always_comb begin
        gnt0     = req0_valid & (~req1_valid | last_q);
        gnt1     = req1_valid & ~gnt0;
        xfer     = gnt0 | gnt1;
        sel_addr = gnt0 ? req0_addr : req1_addr;
        sel_data = gnt0 ? req0_data : req1_data;
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // A register being committed this cycle is no longer a hazard
    assign iss_ready = (iss_rd == '0) | ~pending_q[iss_rd]
                     | (rf_wr_q & (rf_wa_q == iss_rd));
    assign busy1 = (ra1 != '0) & pending_q[ra1] & ~(rf_wr_q & (rf_wa_q == ra1));
    assign busy2 = (ra2 != '0) & pending_q[ra2] & ~(rf_wr_q & (rf_wa_q == ra2));

    assign iss_fire = iss_valid & iss_ready & (iss_rd != '0);

    always_comb begin
        last_d    = last_q;
        rf_wr_d   = 1'b0;
        rf_wa_d   = rf_wa_q;
        rf_wd_d   = rf_wd_q;
        pending_d = pending_q;

        if (xfer) begin
            last_d = gnt1;
            if (sel_addr != '0) begin
                rf_wr_d = 1'b1;
                rf_wa_d = sel_addr;
                rf_wd_d = sel_data;
            end
        end

        // Clear before set so a same-edge re-issue keeps the bit pending
        if (rf_wr_q) begin
            pending_d[rf_wa_q] = 1'b0;
        end
        if (iss_fire) begin
            pending_d[iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q    <= 1'b1;
            rf_wr_q   <= 1'b0;
            rf_wa_q   <= '0;
            rf_wd_q   <= '0;
            pending_q <= '0;
        end else begin
            last_q    <= last_d;
            rf_wr_q   <= rf_wr_d;
            rf_wa_q   <= rf_wa_d;
            rf_wd_q   <= rf_wd_d;
            pending_q <= pending_d;
        end
    end

    assign rf_wr = rf_wr_q;
    assign rf_wa = rf_wa_q;
    assign rf_wd = rf_wd_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: per-cycle reference model check plus
// directed scenarios with hand-computed expectations.
module tb_rf_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid, iss_valid;
    logic [AW-1:0] req0_addr, req1_addr, iss_rd, ra1, ra2;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready, iss_ready, busy1, busy2, rf_wr;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;

    int checks   = 0;
    int failures = 0;

    rf_wb_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
        .req1_ready(req1_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .ra1(ra1), .ra2(ra2), .busy1(busy1), .busy2(busy2),
        .rf_wr(rf_wr), .rf_wa(rf_wa), .rf_wd(rf_wd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who won last, set of pending registers, output register
    int          m_last = 1;
    bit [31:0]   m_pend = '0;
    bit          m_wr   = 1'b0;
    bit [AW-1:0] m_wa   = '0;
    bit [DW-1:0] m_wd   = '0;

    function automatic int winner();
        if (req0_valid && req1_valid) return (m_last == 1) ? 0 : 1;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    function automatic bit committing(input logic [AW-1:0] a);
        return m_wr && (m_wa == a);
    endfunction

    function automatic bit exp_iss_ready();
        return (iss_rd == 0) || !m_pend[iss_rd] || committing(iss_rd);
    endfunction

    function automatic bit exp_busy(input logic [AW-1:0] a);
        return (a != 0) && m_pend[a] && !committing(a);
    endfunction

    function automatic bit [31:0] next_pend();
        bit [31:0] p;
        p = m_pend;
        if (m_wr) p[m_wa] = 1'b0;
        if (iss_valid && exp_iss_ready() && iss_rd != 0) p[iss_rd] = 1'b1;
        return p;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_last <= 1;
            m_pend <= '0;
            m_wr   <= 1'b0;
            m_wa   <= '0;
            m_wd   <= '0;
        end else begin
            m_pend <= next_pend();
            m_wr   <= 1'b0;
            if (winner() >= 0) begin
                m_last <= winner();
                if ((winner() == 0 ? req0_addr : req1_addr) != 0) begin
                    m_wr <= 1'b1;
                    m_wa <= (winner() == 0) ? req0_addr : req1_addr;
                    m_wd <= (winner() == 0) ? req0_data : req1_data;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, winner() == 0});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, winner() == 1});
        chk("one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
        chk("iss_ready", {31'd0, iss_ready}, {31'd0, exp_iss_ready()});
        chk("busy1", {31'd0, busy1}, {31'd0, exp_busy(ra1)});
        chk("busy2", {31'd0, busy2}, {31'd0, exp_busy(ra2)});
        chk("rf_wr", {31'd0, rf_wr}, {31'd0, m_wr});
        chk("rf_wa", {27'd0, rf_wa}, {27'd0, m_wa});
        chk("rf_wd", rf_wd, m_wd);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int          got_g[4];
    logic [AW-1:0] got_wa[4];
    int          exp_g[4]  = '{0, 1, 0, 1};
    int          exp_wa[4] = '{1, 9, 2, 10};

    initial begin
        rst = 1'b0;
        iss_valid = 1'b0; iss_rd = '0; ra1 = 5'd5; ra2 = 5'd6;
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
        req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h66;
        repeat (2) cyc();
        chk("rst_rf_wr", {31'd0, rf_wr}, 32'd0);
        chk("rst_rf_wa", {27'd0, rf_wa}, 32'd0);
        chk("rst_rf_wd", rf_wd, 32'd0);
        chk("rst_busy", {30'd0, busy1, busy2}, 32'd0);
        chk("rst_req0_ready", {31'd0, req0_ready}, 32'd1);
        chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);

        // release: first grant to req0, single write of r5
        rst = 1'b1;
        cyc();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("single_wr", {31'd0, rf_wr}, 32'd1);
        chk("single_wa", {27'd0, rf_wa}, 32'd5);
        chk("single_wd", rf_wd, 32'hDEADBEEF);
        cyc();
        chk("single_wr_off", {31'd0, rf_wr}, 32'd0);
        chk("single_wa_hold", {27'd0, rf_wa}, 32'd5);

        // lone req1 write so req0 wins the first contended cycle
        req1_valid = 1'b1; req1_addr = 5'd20; req1_data = 32'h20;
        cyc();
        req1_valid = 1'b0;
        chk("req1_alone_wa", {27'd0, rf_wa}, 32'd20);

        req0_addr = 5'd1; req0_data = 32'h101;
        req1_addr = 5'd9; req1_data = 32'h109;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            got_g[i] = req1_ready ? 1 : 0;
            cyc();
            got_wa[i] = rf_wa;
            if (got_g[i] == 0) begin
                req0_addr = req0_addr + 5'd1; req0_data = req0_data + 32'd1;
            end else begin
                req1_addr = req1_addr + 5'd1; req1_data = req1_data + 32'd1;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_grant%0d", i), got_g[i], exp_g[i]);
            chk($sformatf("rr_wa%0d", i), {27'd0, got_wa[i]}, exp_wa[i]);
        end
        cyc();

        // RAW on r7
        iss_valid = 1'b1; iss_rd = 5'd7; ra1 = 5'd7; ra2 = 5'd0;
        #2 chk("iss7_ready", {31'd0, iss_ready}, 32'd1);
        cyc();
        chk("raw_busy1", {31'd0, busy1}, 32'd1);
        chk("waw_block", {31'd0, iss_ready}, 32'd0);
        cyc();
        chk("waw_block2", {31'd0, iss_ready}, 32'd0);
        iss_valid = 1'b0;
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h77;
        cyc();
        req1_valid = 1'b0;
        chk("raw_commit_wr", {31'd0, rf_wr}, 32'd1);
        chk("raw_commit_busy", {31'd0, busy1}, 32'd0);
        cyc();
        chk("raw_after_busy", {31'd0, busy1}, 32'd0);

        // r0 never becomes pending and is never written
        iss_valid = 1'b1; iss_rd = 5'd0;
        #2 chk("r0_iss_ready", {31'd0, iss_ready}, 32'd1);
        cyc();
        iss_valid = 1'b0; ra1 = 5'd0;
        chk("r0_busy", {31'd0, busy1}, 32'd0);
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hABC;
        #2 chk("r0_req1_ready", {31'd0, req1_ready}, 32'd1);
        cyc();
        req1_valid = 1'b0;
        chk("r0_no_wr", {31'd0, rf_wr}, 32'd0);
        chk("r0_busy2", {31'd0, busy1}, 32'd0);

        // reset in the middle of a commit with r3, r8 pending
        iss_valid = 1'b1; iss_rd = 5'd3;
        cyc();
        iss_rd = 5'd8;
        cyc();
        iss_valid = 1'b0; ra1 = 5'd8; ra2 = 5'd3;
        req0_valid = 1'b1; req0_addr = 5'd12; req0_data = 32'hC;
        cyc();
        req0_valid = 1'b0;
        chk("mid_wr", {31'd0, rf_wr}, 32'd1);
        chk("mid_busy", {30'd0, busy1, busy2}, 32'd3);
        #2 rst = 1'b0;
        #1;
        chk("arst_wr", {31'd0, rf_wr}, 32'd0);
        chk("arst_busy", {30'd0, busy1, busy2}, 32'd0);
        req0_valid = 1'b1; req0_addr = 5'd13; req0_data = 32'hD;
        req1_valid = 1'b1; req1_addr = 5'd14; req1_data = 32'hE;
        cyc();
        rst = 1'b1;
        #1;
        chk("post_rst_req0", {31'd0, req0_ready}, 32'd1);
        chk("post_rst_req1", {31'd0, req1_ready}, 32'd0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("post_rst_wa", {27'd0, rf_wa}, 32'd13);
        chk("post_rst_busy", {30'd0, busy1, busy2}, 32'd0);
        repeat (2) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        failures++;
        $display("FAIL timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
